// File: rtl/i2s_rx_deserializer_pkg.sv
// Shared I2S definitions for the capture and playback paths.
package i2s_rx_deserializer_pkg;

    // Bit periods between an lrclk edge and the channel MSB.
    localparam int unsigned I2S_DELAY  = 1;
    // lrclk level that marks the left channel.
    localparam logic        LEFT_LEVEL = 1'b0;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_SLOT_W = 32;

    // Legacy state encodings, kept so older code can still compare against them.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LEFT  = ST_LEFT,
        RIGHT = ST_RIGHT
    } i2s_state_e;

endpackage

// File: rtl/i2s_rx_deserializer_sync_fifo.sv
// Synchronous FIFO with a registered head word and occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_drop
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [LVL_W-1:0] r_level;
    logic [WIDTH-1:0] r_head;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [PTR_W-1:0] w_rd_nxt;

    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == LVL_W'(DEPTH));
    assign w_pop    = i_pop && !w_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push   = i_push && (!w_full || w_pop);
    assign w_rd_nxt = w_pop ? r_rd + PTR_W'(1) : r_rd;

    assign o_valid  = !w_empty;
    assign o_data   = r_head;
    assign o_level  = r_level;
    assign o_drop   = i_push && w_full && !w_pop;

    // Storage write; contents need no reset since the level gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + PTR_W'(1);
            end
            r_rd <= w_rd_nxt;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Head register: bypass the incoming word when it lands in the next head slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head <= '0;
        end else if (w_push && (r_wr == w_rd_nxt)) begin
            r_head <= i_data;
        end else begin
            r_head <= r_mem[w_rd_nxt];
        end
    end

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S ADC capture: deserializes left/right samples and queues stereo words.
module i2s_rx_deserializer
    import i2s_rx_deserializer_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned SLOT_W     = DEF_SLOT_W,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          mclk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          bclk,
    input  logic                          lrclk,
    input  logic                          adc_sdata,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [2*DATA_W-1:0]           m_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          frame_err
);

    localparam int unsigned       CNT_W     = $clog2(SLOT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SLOT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_FIRST = CNT_W'(I2S_DELAY);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W);

    logic              r_bclk_d1, r_bclk_d2, r_bclk_d3;
    logic              r_lrclk_d1, r_lrclk_d2;
    logic              r_sdata_d1, r_sdata_d2;
    logic              r_lr_prev;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_left;
    i2s_state_e        r_state;
    logic              r_frame_err;
    logic              r_overflow;

    logic              w_rise;
    logic              w_lr_edge;
    logic              w_left_start;
    logic              w_slot_ok;
    logic [CNT_W-1:0]  w_cnt_nxt;
    i2s_state_e        w_state_nxt;
    logic              w_push;
    logic              w_latch_left;
    logic              w_err;
    logic              w_drop;

    assign w_rise       = r_bclk_d2 && !r_bclk_d3;
    assign w_lr_edge    = (r_lrclk_d2 != r_lr_prev);
    assign w_left_start = w_lr_edge && (r_lrclk_d2 == LEFT_LEVEL);
    // r_cnt still holds the last count of the slot that is ending.
    assign w_slot_ok    = (r_cnt >= CNT_LAST);
    assign w_cnt_nxt    = w_lr_edge ? '0 :
                          (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    assign frame_err    = r_frame_err;
    assign overflow     = r_overflow;

    // Two-stage alignment of bclk/lrclk/data, plus one extra bclk stage for edge detect.
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_bclk_d1  <= 1'b0;
            r_bclk_d2  <= 1'b0;
            r_bclk_d3  <= 1'b0;
            r_lrclk_d1 <= 1'b0;
            r_lrclk_d2 <= 1'b0;
            r_sdata_d1 <= 1'b0;
            r_sdata_d2 <= 1'b0;
        end else begin
            r_bclk_d1  <= bclk;
            r_bclk_d2  <= r_bclk_d1;
            r_bclk_d3  <= r_bclk_d2;
            r_lrclk_d1 <= lrclk;
            r_lrclk_d2 <= r_lrclk_d1;
            r_sdata_d1 <= adc_sdata;
            r_sdata_d2 <= r_sdata_d1;
        end
    end

    // Bit counter and MSB-first shifter, advanced on each bclk rise.
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_lr_prev <= 1'b0;
            r_cnt     <= '0;
            r_shift   <= '0;
        end else if (w_rise) begin
            r_lr_prev <= r_lrclk_d2;
            r_cnt     <= w_cnt_nxt;
            if ((w_cnt_nxt >= CNT_FIRST) && (w_cnt_nxt <= CNT_LAST)) begin
                r_shift <= {r_shift[DATA_W-2:0], r_sdata_d2};
            end
        end
    end

    // Frame sequencing: decide slot completion at each lrclk edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_push       = 1'b0;
        w_latch_left = 1'b0;
        w_err        = 1'b0;
        if (!en) begin
            w_state_nxt = IDLE;
        end else if (w_rise && w_lr_edge) begin
            case (r_state)
                IDLE: begin
                    if (w_left_start) begin
                        w_state_nxt = LEFT;
                    end
                end
                LEFT: begin
                    if (!w_left_start) begin
                        if (w_slot_ok) begin
                            w_latch_left = 1'b1;
                            w_state_nxt  = RIGHT;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end
                end
                RIGHT: begin
                    if (w_left_start) begin
                        if (w_slot_ok) begin
                            w_push      = 1'b1;
                            w_state_nxt = LEFT;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM state, left-sample holding register and error pulse.
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_left      <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_err <= w_err;
            if (w_latch_left) begin
                r_left <= r_shift;
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (mclk),
        .i_rst   (reset),
        .i_push  (w_push),
        .i_data  ({r_left, r_shift}),
        .i_pop   (m_ready),
        .o_valid (m_valid),
        .o_data  (m_data),
        .o_level (fifo_level),
        .o_drop  (w_drop)
    );

endmodule
